ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX/MEM pipeline register with a valid/ready handshake, stall support,

---
 rtl/mips_pipe_pkg.sv | 32 +++
 rtl/pipe_skid_buf.sv | 73 +++++++
 rtl/ex_mem_pipe_stage.sv | 78 +++++++
 tb/tb_ex_mem_pipe_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-style pipeline registers: MEM control bit
// positions, the EX/MEM payload record and the branch condition helper.
package mips_pipe_pkg;

  localparam int MEM_W      = 4;
  localparam int EQ_NE_B    = 3;
  localparam int BRANCH_B   = 2;
  localparam int MEMREAD_B  = 1;
  localparam int MEMWRITE_B = 0;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;
  localparam int DEF_WB_W = 2;

  // Field order matches the packing order used by ex_mem_pipe_stage (MSB first)
  typedef struct packed {
    logic [DEF_WB_W-1:0] wb;
    logic [MEM_W-1:0]    mem;
    logic [DEF_XLEN-1:0] pc;
    logic                eq;
    logic                ne;
    logic [DEF_XLEN-1:0] alu;
    logic [DEF_XLEN-1:0] rd2;
    logic [DEF_RA_W-1:0] dst;
  } ex_mem_payload_t;

  // eq_ne selects BNE (ne flag) instead of BEQ (eq flag)
  function automatic logic branch_cond(input logic eq_ne, input logic eq, input logic ne);
    return eq_ne ? ne : eq;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice on a W-bit vector: one main entry plus an
// optional skid entry that keeps in_ready a pure register output.
module pipe_skid_buf #(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic         main_valid_reg, main_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] main_data_reg, main_data_next;
  logic [W-1:0] skid_data_reg, skid_data_next;
  logic         accept;
  logic         drain;

  assign in_ready  = SKID ? !skid_valid_reg : (!main_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_reg && out_ready;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_data_next  = main_data_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || drain) begin
      // Main slot frees up: oldest held beat (skid) goes first to keep FIFO order
      if (skid_valid_reg) begin
        main_data_next  = skid_data_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_data_next  = in_data;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept && SKID) begin
      skid_data_next  = in_data;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register: buffers the EX beat, decodes the MEM control bundle
// and resolves branch-taken; control outputs read as a bubble when no beat is held.
module ex_mem_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int WB_W = 2,
  parameter int SKID = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WB_W-1:0]  wb_ctl_in,
  input  logic [3:0]       mem_ctl_in,
  input  logic [XLEN-1:0]  bran_pc_in,
  input  logic             eq_in,
  input  logic             ne_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  rd2_in,
  input  logic [RA_W-1:0]  reg_dst_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WB_W-1:0]  wb_ctl_out,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             eq_ne,
  output logic [XLEN-1:0]  bran_pc_out,
  output logic [XLEN-1:0]  alu_result_out,
  output logic [XLEN-1:0]  wd_out,
  output logic             eq_out,
  output logic             ne_out,
  output logic [RA_W-1:0]  reg_dst_out,
  output logic             branch_taken,
  output logic [1:0]       occupancy
);

  localparam int PW = WB_W + MEM_W + 3 * XLEN + 2 + RA_W;

  logic [PW-1:0]    in_data;
  logic [PW-1:0]    out_data;
  logic [WB_W-1:0]  wb_held;
  logic [MEM_W-1:0] mem_held;

  assign in_data = {wb_ctl_in, mem_ctl_in, bran_pc_in, eq_in, ne_in,
                    alu_result_in, rd2_in, reg_dst_in};

  pipe_skid_buf #(
    .W    (PW),
    .SKID (SKID != 0)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  assign {wb_held, mem_held, bran_pc_out, eq_out, ne_out,
          alu_result_out, wd_out, reg_dst_out} = out_data;

  // Payload stays visible when idle; only control is forced to a bubble
  assign wb_ctl_out   = out_valid ? wb_held : '0;
  assign mem_read     = out_valid && mem_held[MEMREAD_B];
  assign mem_write    = out_valid && mem_held[MEMWRITE_B];
  assign branch       = out_valid && mem_held[BRANCH_B];
  assign eq_ne        = out_valid && mem_held[EQ_NE_B];
  assign branch_taken = branch && branch_cond(mem_held[EQ_NE_B], eq_out, ne_out);

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: one instance with the skid buffer, one without,
// exercised in turn against a queue-based model of the held beats.
module tb_ex_mem_pipe_stage;
  import mips_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush [2];
  logic        in_valid [2];
  logic        out_ready [2];
  logic [1:0]  wb_in;
  logic [3:0]  mem_in;
  logic [31:0] pc_in, alu_in, rd2_in;
  logic        eq_in, ne_in;
  logic [4:0]  dst_in;

  logic        in_ready [2];
  logic        out_valid [2];
  logic [1:0]  wb_o [2];
  logic        mrd_o [2], mwr_o [2], br_o [2], eqne_o [2], bt_o [2];
  logic [31:0] pc_o [2], alu_o [2], wd_o [2];
  logic        eq_o [2], ne_o [2];
  logic [4:0]  dst_o [2];
  logic [1:0]  occ_o [2];

  // Instance 0 has the skid buffer, instance 1 is the single-entry build
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ex_mem_pipe_stage #(
      .XLEN(32), .RA_W(5), .WB_W(2), .SKID(gi == 0 ? 1 : 0)
    ) dut (
      .clk(clk), .rst(rst), .flush(flush[gi]),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .wb_ctl_in(wb_in), .mem_ctl_in(mem_in), .bran_pc_in(pc_in),
      .eq_in(eq_in), .ne_in(ne_in), .alu_result_in(alu_in),
      .rd2_in(rd2_in), .reg_dst_in(dst_in),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .wb_ctl_out(wb_o[gi]), .mem_read(mrd_o[gi]), .mem_write(mwr_o[gi]),
      .branch(br_o[gi]), .eq_ne(eqne_o[gi]),
      .bran_pc_out(pc_o[gi]), .alu_result_out(alu_o[gi]), .wd_out(wd_o[gi]),
      .eq_out(eq_o[gi]), .ne_out(ne_o[gi]), .reg_dst_out(dst_o[gi]),
      .branch_taken(bt_o[gi]), .occupancy(occ_o[gi])
    );
  end

  ex_mem_payload_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cur_k = 0;
  bit acc_flag = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d t=%0t got=%h expected=%h", name, cur_k, $time, act, exp);
    end
  endtask

  // Model + monitor: compare what the DUT presents with the oldest held beat,
  // then apply this cycle's transfer, flush and accept to the model queue.
  always @(negedge clk) begin
    ex_mem_payload_t got, exp, beat;
    logic [6:0] ctl_got, ctl_exp;
    logic model_rdy;
    int k;
    k = cur_k;
    if (rst) begin
      acc_flag = 1'b0;
    end else begin
      model_rdy = (k == 0) ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready[k]);
      chk("in_ready", 128'(in_ready[k]), 128'(model_rdy));
      chk("occupancy", 128'(occ_o[k]), 128'(exp_q.size()));
      chk("out_valid", 128'(out_valid[k]), 128'(exp_q.size() != 0));
      ctl_got = {wb_o[k], mrd_o[k], mwr_o[k], br_o[k], eqne_o[k], bt_o[k]};
      if (exp_q.size() != 0) begin
        exp = exp_q[0];
        got = '{wb: wb_o[k], mem: {eqne_o[k], br_o[k], mrd_o[k], mwr_o[k]},
                pc: pc_o[k], eq: eq_o[k], ne: ne_o[k], alu: alu_o[k],
                rd2: wd_o[k], dst: dst_o[k]};
        chk("payload", 128'(got), 128'(exp));
        ctl_exp = {exp.wb, exp.mem[1], exp.mem[0], exp.mem[2], exp.mem[3],
                   exp.mem[2] & (exp.mem[3] ? exp.ne : exp.eq)};
        chk("ctl", 128'(ctl_got), 128'(ctl_exp));
        if (out_ready[k]) begin
          $display("[TB] k=%0d out alu=%h pc=%h dst=%0d", k, exp.alu, exp.pc, exp.dst);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("bubble_ctl", 128'(ctl_got), 128'(0));
      end
      acc_flag = 1'b0;
      if (flush[k]) begin
        exp_q.delete();
      end else if (in_valid[k] && model_rdy) begin
        beat = '{wb: wb_in, mem: mem_in, pc: pc_in, eq: eq_in, ne: ne_in,
                 alu: alu_in, rd2: rd2_in, dst: dst_in};
        exp_q.push_back(beat);
        acc_flag = 1'b1;
      end
    end
  end

  task automatic set_beat(input logic [31:0] alu);
    wb_in  = 2'($urandom);
    mem_in = 4'($urandom);
    pc_in  = $urandom;
    eq_in  = 1'($urandom);
    ne_in  = 1'($urandom);
    alu_in = alu;
    rd2_in = $urandom;
    dst_in = 5'($urandom);
  endtask

  // Present the current beat until the model reports it accepted
  task automatic send();
    int n;
    n = 0;
    in_valid[cur_k] = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 60);
    chk("send_timeout", 128'(n < 60), 128'(1));
    in_valid[cur_k] = 1'b0;
  endtask

  task automatic drain();
    out_ready[cur_k] = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic hold_beats(input int nh);
    out_ready[cur_k] = 1'b0;
    for (int i = 0; i < nh; i++) begin
      set_beat(32'h200 + 32'(i));
      mem_in = 4'b0001;
      wb_in  = 2'b11;
      send();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    end
    set_beat(32'h0);
    #1;
    for (int i = 0; i < 2; i++) begin
      cur_k = i;
      chk("rst_in_ready", 128'(in_ready[i]), 128'(1));
      chk("rst_out_valid", 128'(out_valid[i]), 128'(0));
      chk("rst_occ", 128'(occ_o[i]), 128'(0));
    end
    cur_k = 0;
    @(posedge clk); #3 rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      int nh;
      cur_k = k;
      nh = (k == 0) ? 2 : 1;
      @(posedge clk); #1;

      // Streaming: one beat per cycle, each visible one cycle after acceptance
      out_ready[k] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        set_beat(32'h100 + 32'(i));
        send();
        chk("stream_alu", 128'(alu_o[k]), 128'(32'h100 + 32'(i)));
        chk("stream_valid", 128'(out_valid[k]), 128'(1));
      end
      drain();

      // Stall: four beats against a 3-cycle hold on out_ready
      out_ready[k] = 1'b0;
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            set_beat(32'hA0 + 32'(i));
            send();
          end
        end
        begin
          repeat (3) @(posedge clk);
          #2;
          chk("stall_occ", 128'(occ_o[k]), 128'(nh));
          chk("stall_in_ready", 128'(in_ready[k]), 128'(0));
          out_ready[k] = 1'b1;
          #1;
          chk("release_in_ready", 128'(in_ready[k]), 128'(k == 1));
        end
      join
      drain();

      // Flush with held beats and a same-cycle incoming beat
      hold_beats(nh);
      set_beat(32'hDEAD);
      mem_in = 4'b0001;
      wb_in  = 2'b10;
      in_valid[k] = 1'b1;
      flush[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      flush[k] = 1'b0;
      chk("flush_valid", 128'(out_valid[k]), 128'(0));
      chk("flush_mem_write", 128'(mwr_o[k]), 128'(0));
      chk("flush_wb", 128'(wb_o[k]), 128'(0));
      chk("flush_occ", 128'(occ_o[k]), 128'(0));
      drain();

      // Branch resolve
      out_ready[k] = 1'b1;
      set_beat(32'h300); mem_in = 4'b0100; eq_in = 1'b1;
      send();
      chk("branch_beq_taken", 128'(bt_o[k]), 128'(1));
      set_beat(32'h301); mem_in = 4'b1100; ne_in = 1'b0;
      send();
      chk("branch_bne_not", 128'(bt_o[k]), 128'(0));
      set_beat(32'h302); mem_in = 4'b1100; ne_in = 1'b1; eq_in = 1'b0;
      send();
      chk("branch_bne_taken", 128'(bt_o[k]), 128'(1));
      @(posedge clk); #1;
      chk("branch_idle", 128'(bt_o[k]), 128'(0));
      drain();

      // Randomized traffic with occasional flushes
      for (int c = 0; c < 300; c++) begin
        set_beat($urandom);
        in_valid[k]  = ($urandom_range(3) != 0);
        out_ready[k] = ($urandom_range(2) != 0);
        flush[k]     = ($urandom_range(31) == 0);
        @(posedge clk); #1;
      end
      in_valid[k] = 1'b0;
      flush[k] = 1'b0;
      drain();

      // Asynchronous reset in mid-cycle while beats are held
      hold_beats(nh);
      #2 rst = 1'b1;
      #1;
      chk("areset_valid", 128'(out_valid[k]), 128'(0));
      chk("areset_in_ready", 128'(in_ready[k]), 128'(1));
      chk("areset_occ", 128'(occ_o[k]), 128'(0));
      chk("areset_payload", 128'({pc_o[k], alu_o[k], wd_o[k], dst_o[k], eq_o[k], ne_o[k]}), 128'(0));
      chk("areset_ctl", 128'({wb_o[k], mrd_o[k], mwr_o[k], br_o[k], eqne_o[k], bt_o[k]}), 128'(0));
      exp_q.delete();
      @(posedge clk); #3 rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
